// File: rtl/ipg_pkg.sv
// Shared IPG write-request definitions, used by both the transmit-side generator
// and the receive-side parser.
//   - widths of the header fields, chunk and payload
//   - header bit offsets and the minimum slot that fits a whole header
//   - generator state enum
//   - ipg_header / ipg_extract: build a header chunk and cut an MSB-aligned
//     payload window into a chunk
package ipg_pkg;

    localparam int unsigned HDR_WIDTH     = 16;   // length field, payload bits
    localparam int unsigned ADR_WIDTH     = 12;
    localparam int unsigned DATA_WIDTH    = 64;
    localparam int unsigned PAYLOAD_LEN   = 512;
    localparam int unsigned PAYLOAD_COUNT = 10;
    localparam int unsigned LEN_WIDTH     = 6;    // width of slot / tx_len fields
    localparam int unsigned HDR_SLOT_MIN  = HDR_WIDTH + ADR_WIDTH;

    // Header layout, MSB-aligned in the chunk
    localparam int unsigned HDR_LEN_MSB = DATA_WIDTH - 1;
    localparam int unsigned HDR_ADR_MSB = HDR_LEN_MSB - HDR_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StData
    } ipg_state_e;

    function automatic logic [DATA_WIDTH-1:0] ipg_header(
        input logic [PAYLOAD_COUNT-1:0] len,
        input logic [ADR_WIDTH-1:0]     addr
    );
        logic [DATA_WIDTH-1:0] hdr;
        hdr = '0;
        hdr[HDR_LEN_MSB -: HDR_WIDTH] = HDR_WIDTH'(len);
        hdr[HDR_ADR_MSB -: ADR_WIDTH] = addr;
        return hdr;
    endfunction

    // Returns payload[remaining-1 -: n] placed at [DATA_WIDTH-1 -: n], other bits 0.
    // The payload is first shifted so bit remaining-1 lands on the top bit; bits above
    // it fall off, bits below the window are masked away.
    function automatic logic [DATA_WIDTH-1:0] ipg_extract(
        input logic [PAYLOAD_LEN-1:0]   payload,
        input logic [PAYLOAD_COUNT-1:0] remaining,
        input logic [LEN_WIDTH-1:0]     n
    );
        logic [PAYLOAD_COUNT-1:0] shamt;
        logic [PAYLOAD_LEN-1:0]   aligned;
        logic [DATA_WIDTH-1:0]    mask;
        shamt   = PAYLOAD_COUNT'(PAYLOAD_LEN) - remaining;
        aligned = payload << shamt;
        mask    = ~({DATA_WIDTH{1'b1}} >> n);
        return aligned[PAYLOAD_LEN-1 -: DATA_WIDTH] & mask;
    endfunction

endpackage

// File: rtl/ipg_wreq_gen.sv
// IPG write-request generator. Accepts one request (address + payload) and emits it
// as inter-packet-gap chunks: first a 28-bit header {len, addr}, then the payload
// MSB-first, each chunk sized by the free slot advertised that cycle.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req_valid/ready request handshake; ready only while idle
//   req_addr        target address
//   req_len         payload length in bits (clamped to PAYLOAD_LEN)
//   req_payload     payload, bit req_len-1 sent first
//   ipg_slot_len    free bits in the slot the chunk launched this edge occupies
//   tx_ipg_data     registered chunk, MSB-aligned, unused LSBs zero
//   tx_len          registered valid-bit count, 0 when no chunk
//   wreq_valid      registered one-cycle chunk strobe
//   busy            request in flight
module ipg_wreq_gen
    import ipg_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADR_WIDTH-1:0]     req_addr,
    input  logic [PAYLOAD_COUNT-1:0] req_len,
    input  logic [PAYLOAD_LEN-1:0]   req_payload,
    input  logic [LEN_WIDTH-1:0]     ipg_slot_len,
    output logic [DATA_WIDTH-1:0]    tx_ipg_data,
    output logic [LEN_WIDTH-1:0]     tx_len,
    output logic                     wreq_valid,
    output logic                     busy
);

    ipg_state_e               state_q, state_d;
    logic [ADR_WIDTH-1:0]     addr_q, addr_d;
    logic [PAYLOAD_LEN-1:0]   payload_q, payload_d;
    logic [PAYLOAD_COUNT-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
    logic [LEN_WIDTH-1:0]     tx_len_q, tx_len_d;
    logic                     wreq_valid_q, wreq_valid_d;

    logic [PAYLOAD_COUNT-1:0] len_eff;
    logic [LEN_WIDTH-1:0]     chunk_n;

    always_comb begin
        len_eff = (req_len > PAYLOAD_COUNT'(PAYLOAD_LEN)) ? PAYLOAD_COUNT'(PAYLOAD_LEN) : req_len;
        // Clamp to what is left so rem_q can never underflow
        chunk_n = (PAYLOAD_COUNT'(ipg_slot_len) < rem_q) ? ipg_slot_len
                                                         : rem_q[LEN_WIDTH-1:0];
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        payload_d    = payload_q;
        rem_d        = rem_q;
        tx_data_d    = '0;
        tx_len_d     = '0;
        wreq_valid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Zero-length requests are consumed and dropped
                if (req_valid && (len_eff != '0)) begin
                    addr_d    = req_addr;
                    payload_d = req_payload;
                    rem_d     = len_eff;
                    state_d   = StHdr;
                end
            end
            StHdr: begin
                // The header is never split across slots
                if (ipg_slot_len >= LEN_WIDTH'(HDR_SLOT_MIN)) begin
                    tx_data_d    = ipg_header(rem_q, addr_q);
                    tx_len_d     = LEN_WIDTH'(HDR_SLOT_MIN);
                    wreq_valid_d = 1'b1;
                    state_d      = StData;
                end
            end
            StData: begin
                if (chunk_n != '0) begin
                    tx_data_d    = ipg_extract(payload_q, rem_q, chunk_n);
                    tx_len_d     = chunk_n;
                    wreq_valid_d = 1'b1;
                    rem_d        = rem_q - PAYLOAD_COUNT'(chunk_n);
                    if (rem_q == PAYLOAD_COUNT'(chunk_n)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            payload_q    <= '0;
            rem_q        <= '0;
            tx_data_q    <= '0;
            tx_len_q     <= '0;
            wreq_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            payload_q    <= payload_d;
            rem_q        <= rem_d;
            tx_data_q    <= tx_data_d;
            tx_len_q     <= tx_len_d;
            wreq_valid_q <= wreq_valid_d;
        end
    end

    assign req_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign tx_ipg_data = tx_data_q;
    assign tx_len      = tx_len_q;
    assign wreq_valid  = wreq_valid_q;

endmodule

// File: tb/tb_ipg_wreq_gen.sv
// Bench for ipg_wreq_gen: a per-cycle vector table for the basic header/data
// sequences, then model-checked messages (full length, oversize, stalled slots,
// random slots with reassembly) and a reset in the middle of a message.
module tb_ipg_wreq_gen;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [11:0]  req_addr;
    logic [9:0]   req_len;
    logic [511:0] req_payload;
    logic [5:0]   ipg_slot_len;
    logic [63:0]  tx_ipg_data;
    logic [5:0]   tx_len;
    logic         wreq_valid;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    ipg_wreq_gen dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_payload  (req_payload),
        .ipg_slot_len (ipg_slot_len),
        .tx_ipg_data  (tx_ipg_data),
        .tx_len       (tx_len),
        .wreq_valid   (wreq_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        req_valid;
        logic [11:0] addr;
        logic [9:0]  len;
        logic [63:0] pay;
        logic [5:0]  slot;
        logic        exp_wv;
        logic [5:0]  exp_len;
        logic [63:0] exp_data;
        logic        exp_ready;
        logic        exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [11:0] addr, input logic [9:0] len,
                          input logic [511:0] pay);
        req_valid   = 1'b1;
        req_addr    = addr;
        req_len     = len;
        req_payload = pay;
        step();
        req_valid   = 1'b0;
    endtask

    // Sends one request and checks every following cycle against a model of the
    // chunking rules; reassembles the payload like the receiver would.
    // mode 0: slot 63, mode 1: slot alternates 63/0, mode 2: random slot.
    task automatic run_msg(input string tag, input logic [11:0] addr, input logic [9:0] len,
                           input logic [511:0] pay, input int mode,
                           output int chunks, output int last_len);
        int           eff;
        int           got;
        int           cyc;
        int           exp_n;
        bit           hdr_seen;
        bit           exp_v;
        logic [5:0]   s;
        logic [511:0] recv;
        logic [511:0] mask;
        logic [63:0]  exp_hdr;
        eff      = (len > 10'd512) ? 512 : int'(len);
        got      = 0;
        cyc      = 0;
        chunks   = 0;
        last_len = 0;
        hdr_seen = 1'b0;
        recv     = '0;
        exp_hdr  = {16'(eff), addr, 36'h0};
        accept(addr, len, pay);
        while (got < eff && cyc < 4000) begin
            case (mode)
                0:       s = 6'd63;
                1:       s = (cyc % 2 == 0) ? 6'd63 : 6'd0;
                default: s = 6'($urandom_range(0, 63));
            endcase
            ipg_slot_len = s;
            step();
            cyc++;
            exp_n = (int'(s) < eff - got) ? int'(s) : eff - got;
            exp_v = hdr_seen ? (exp_n > 0) : (s >= 6'd28);
            check({tag, " wreq_valid"}, 64'(wreq_valid), 64'(exp_v));
            if (wreq_valid && !hdr_seen) begin
                hdr_seen = 1'b1;
                check({tag, " hdr data"}, tx_ipg_data, exp_hdr);
                check({tag, " hdr len"}, 64'(tx_len), 64'd28);
            end else if (wreq_valid) begin
                check({tag, " chunk len"}, 64'(tx_len), 64'(exp_n));
                check({tag, " chunk lsbs"}, tx_ipg_data << tx_len, 64'h0);
                if (tx_len != 6'd0) begin
                    recv = (recv << tx_len) | (512'(tx_ipg_data) >> (7'd64 - 7'(tx_len)));
                end
                got      = got + int'(tx_len);
                last_len = int'(tx_len);
                chunks++;
            end else begin
                check({tag, " idle len"}, 64'(tx_len), 64'h0);
            end
        end
        check({tag, " bits delivered"}, 64'(got), 64'(eff));
        mask = {512{1'b1}} >> (512 - eff);
        check({tag, " payload lo"}, recv[63:0], pay[63:0] & mask[63:0]);
        check({tag, " payload all"}, 64'(recv == (pay & mask)), 64'h1);
        check({tag, " ready after"}, 64'(req_ready), 64'h1);
        check({tag, " busy after"}, 64'(busy), 64'h0);
    endtask

    vec_t          vecs[15];
    logic [511:0]  pay;
    int            chunks;
    int            last_len;

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_len      = '0;
        req_payload  = '0;
        ipg_slot_len = '0;
        step();
        step();
        check("reset wreq_valid", 64'(wreq_valid), 64'h0);
        check("reset tx_len", 64'(tx_len), 64'h0);
        check("reset tx_data", tx_ipg_data, 64'h0);
        check("reset ready", 64'(req_ready), 64'h1);
        check("reset busy", 64'(busy), 64'h0);
        reset = 1'b0;

        // Basic header + single chunk, stalled header then 16/16/8 split with a
        // request ignored while busy, then zero-length drops.
        vecs[0]  = '{1'b1, 12'hABC, 10'd40, 64'hF0_1234_5678, 6'd63,
                     1'b0, 6'd0, 64'h0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 12'h0, 10'd0, 64'h0, 6'd63,
                     1'b1, 6'd28, 64'h0028_ABC0_0000_0000, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 12'h0, 10'd0, 64'h0, 6'd63,
                     1'b1, 6'd40, 64'hF012_3456_7800_0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 12'h0, 10'd0, 64'h0, 6'd63,
                     1'b0, 6'd0, 64'h0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 12'hABC, 10'd40, 64'hF0_1234_5678, 6'd16,
                     1'b0, 6'd0, 64'h0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 12'h123, 10'd8, 64'hFF, 6'd16,
                     1'b0, 6'd0, 64'h0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 12'h123, 10'd8, 64'hFF, 6'd16,
                     1'b0, 6'd0, 64'h0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 12'h0, 10'd0, 64'h0, 6'd28,
                     1'b1, 6'd28, 64'h0028_ABC0_0000_0000, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 12'h0, 10'd0, 64'h0, 6'd16,
                     1'b1, 6'd16, 64'hF012_0000_0000_0000, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 12'h0, 10'd0, 64'h0, 6'd16,
                     1'b1, 6'd16, 64'h3456_0000_0000_0000, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 12'h0, 10'd0, 64'h0, 6'd16,
                     1'b1, 6'd8, 64'h7800_0000_0000_0000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 12'h0, 10'd0, 64'h0, 6'd0,
                     1'b0, 6'd0, 64'h0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 12'h5A5, 10'd0, 64'hF0_1234_5678, 6'd63,
                     1'b0, 6'd0, 64'h0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 12'h5A5, 10'd0, 64'hF0_1234_5678, 6'd63,
                     1'b0, 6'd0, 64'h0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 12'h0, 10'd0, 64'h0, 6'd63,
                     1'b0, 6'd0, 64'h0, 1'b1, 1'b0};

        for (int i = 0; i < 15; i++) begin
            req_valid    = vecs[i].req_valid;
            req_addr     = vecs[i].addr;
            req_len      = vecs[i].len;
            req_payload  = {448'h0, vecs[i].pay};
            ipg_slot_len = vecs[i].slot;
            step();
            check($sformatf("vec%0d wreq_valid", i), 64'(wreq_valid), 64'(vecs[i].exp_wv));
            check($sformatf("vec%0d tx_len", i), 64'(tx_len), 64'(vecs[i].exp_len));
            check($sformatf("vec%0d tx_data", i), tx_ipg_data, vecs[i].exp_data);
            check($sformatf("vec%0d ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            check($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].exp_busy));
        end
        req_valid = 1'b0;

        // Full-size all-ones message: 8 x 63 + 8 = 512
        run_msg("full", 12'h0F1, 10'd512, {512{1'b1}}, 0, chunks, last_len);
        check("full chunk count", 64'(chunks), 64'd9);
        check("full last len", 64'(last_len), 64'd8);

        // Oversize request is clamped to 512 (header checked inside run_msg)
        for (int k = 0; k < 16; k++) pay[k*32 +: 32] = $urandom();
        run_msg("clamp", 12'h7E7, 10'd700, pay, 0, chunks, last_len);
        check("clamp chunk count", 64'(chunks), 64'd9);

        // Slot alternates with empty slots during data
        for (int k = 0; k < 16; k++) pay[k*32 +: 32] = $urandom();
        run_msg("toggle", 12'h246, 10'd200, pay, 1, chunks, last_len);
        check("toggle chunk count", 64'(chunks), 64'd4);

        // Reset after the second data chunk abandons the message
        for (int k = 0; k < 16; k++) pay[k*32 +: 32] = $urandom();
        accept(12'h3C3, 10'd300, pay);
        ipg_slot_len = 6'd63;
        step();
        step();
        step();
        check("pre-reset wreq_valid", 64'(wreq_valid), 64'h1);
        check("pre-reset tx_len", 64'(tx_len), 64'd63);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid-reset wreq_valid", 64'(wreq_valid), 64'h0);
        check("mid-reset tx_len", 64'(tx_len), 64'h0);
        check("mid-reset tx_data", tx_ipg_data, 64'h0);
        check("mid-reset ready", 64'(req_ready), 64'h1);
        check("mid-reset busy", 64'(busy), 64'h0);

        // Random loopback messages
        for (int m = 0; m < 8; m++) begin
            for (int k = 0; k < 16; k++) pay[k*32 +: 32] = $urandom();
            run_msg($sformatf("rand%0d", m), 12'($urandom()), 10'($urandom_range(1, 700)),
                    pay, 2, chunks, last_len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
